// File: rtl/keypad_pkg.sv
// Shared constants and decode helpers for the 4x3 keypad scanner.
// Key codes, FSM state encodings and the row/column to key-code map.
package keypad_pkg;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;
    localparam logic [3:0] KEY_NONE = 4'hF;

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_PRESSED  = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    // Map (row, col) to a key code: r0 1 2 3 | r1 4 5 6 | r2 7 8 9 | r3 * 0 #
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code_s;
        code_s = KEY_NONE;
        if (col == 2'd3) begin
            code_s = KEY_NONE;
        end else begin
            case (row)
                2'd0:    code_s = 4'd1 + {2'b00, col};
                2'd1:    code_s = 4'd4 + {2'b00, col};
                2'd2:    code_s = 4'd7 + {2'b00, col};
                2'd3: begin
                    case (col)
                        2'd0:    code_s = KEY_STAR;
                        2'd1:    code_s = 4'd0;
                        2'd2:    code_s = KEY_HASH;
                        default: code_s = KEY_NONE;
                    endcase
                end
                default: code_s = KEY_NONE;
            endcase
        end
        return code_s;
    endfunction

    function automatic logic one_low(input logic [2:0] col);
        logic hit_s;
        case (col)
            3'b110, 3'b101, 3'b011: hit_s = 1'b1;
            default:                hit_s = 1'b0;
        endcase
        return hit_s;
    endfunction

    function automatic logic [1:0] low_index(input logic [2:0] col);
        logic [1:0] idx_s;
        case (col)
            3'b110:  idx_s = 2'd0;
            3'b101:  idx_s = 2'd1;
            3'b011:  idx_s = 2'd2;
            default: idx_s = 2'd0;
        endcase
        return idx_s;
    endfunction

    function automatic logic [1:0] row_index(input logic [3:0] row_n);
        logic [1:0] idx_s;
        case (row_n)
            4'b1110: idx_s = 2'd0;
            4'b1101: idx_s = 2'd1;
            4'b1011: idx_s = 2'd2;
            4'b0111: idx_s = 2'd3;
            default: idx_s = 2'd0;
        endcase
        return idx_s;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; resets to all ones so
// pulled-up lines read as idle while reset is applied.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_r <= {WIDTH{1'b1}};
            sync_r <= {WIDTH{1'b1}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner with press/release debounce; emits one key code
// and a single-cycle key_valid strobe per physical press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] row_n,
    input  logic [2:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int STEP_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W  = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  CNT_ZERO  = {DEB_W{1'b0}};
    localparam logic [DEB_W-1:0]  CNT_ONE   = DEB_W'(1);
    localparam logic [DEB_W-1:0]  CNT_LAST  = DEB_W'(DEBOUNCE_CNT - 1);
    localparam logic [DEB_W-1:0]  CNT_DONE  = DEB_W'(DEBOUNCE_CNT);

    logic [2:0]        col_s;
    logic [2:0]        lat_pat_s;
    logic              lat_high_s;

    logic [1:0]        state_r,    state_s;
    logic [3:0]        row_n_r,    row_n_s;
    logic [STEP_W-1:0] step_cnt_r, step_cnt_s;
    logic [DEB_W-1:0]  deb_cnt_r,  deb_cnt_s;
    logic [DEB_W-1:0]  rel_cnt_r,  rel_cnt_s;
    logic [1:0]        lat_row_r,  lat_row_s;
    logic [1:0]        lat_col_r,  lat_col_s;
    logic [3:0]        key_code_r, key_code_s;
    logic              key_valid_r, key_valid_s;
    logic              key_held_r,  key_held_s;

    sync_2ff #(.WIDTH(3)) u_col_sync (
        .clk   (clk),
        .reset (reset),
        .d     (col_n),
        .q     (col_s)
    );

    assign lat_pat_s  = ~(3'b001 << lat_col_r);
    assign lat_high_s = col_s[lat_col_r];

    // Next-state logic: scan rows, debounce a single-column press, track release
    always_comb begin
        state_s     = state_r;
        row_n_s     = row_n_r;
        step_cnt_s  = step_cnt_r;
        deb_cnt_s   = deb_cnt_r;
        rel_cnt_s   = rel_cnt_r;
        lat_row_s   = lat_row_r;
        lat_col_s   = lat_col_r;
        key_code_s  = key_code_r;
        key_valid_s = 1'b0;
        key_held_s  = key_held_r;
        case (state_r)
            ST_SCAN: begin
                if (step_cnt_r == STEP_LAST) begin
                    step_cnt_s = STEP_ZERO;
                    // Two or more lows on one row is a ghost and is skipped like an idle row
                    if (one_low(col_s)) begin
                        lat_row_s = row_index(row_n_r);
                        lat_col_s = low_index(col_s);
                        deb_cnt_s = CNT_ONE;
                        state_s   = ST_DEBOUNCE;
                    end else begin
                        row_n_s = {row_n_r[2:0], row_n_r[3]};
                    end
                end else begin
                    step_cnt_s = step_cnt_r + STEP_ONE;
                end
            end
            ST_DEBOUNCE: begin
                if (col_s == lat_pat_s) begin
                    if (deb_cnt_r >= CNT_LAST) begin
                        deb_cnt_s   = CNT_DONE;
                        key_code_s  = key_map(lat_row_r, lat_col_r);
                        key_valid_s = 1'b1;
                        key_held_s  = 1'b1;
                        state_s     = ST_PRESSED;
                    end else begin
                        deb_cnt_s = deb_cnt_r + CNT_ONE;
                    end
                end else begin
                    deb_cnt_s  = CNT_ZERO;
                    step_cnt_s = STEP_ZERO;
                    state_s    = ST_SCAN;
                end
            end
            ST_PRESSED: begin
                if (lat_high_s) begin
                    rel_cnt_s = CNT_ONE;
                    state_s   = ST_RELEASE;
                end else begin
                    rel_cnt_s = CNT_ZERO;
                end
            end
            ST_RELEASE: begin
                if (!lat_high_s) begin
                    rel_cnt_s = CNT_ZERO;
                    state_s   = ST_PRESSED;
                end else if (rel_cnt_r >= CNT_LAST) begin
                    rel_cnt_s  = CNT_ZERO;
                    deb_cnt_s  = CNT_ZERO;
                    key_held_s = 1'b0;
                    row_n_s    = {row_n_r[2:0], row_n_r[3]};
                    step_cnt_s = STEP_ZERO;
                    state_s    = ST_SCAN;
                end else begin
                    rel_cnt_s = rel_cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_SCAN;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_SCAN;
            row_n_r     <= 4'b1110;
            step_cnt_r  <= STEP_ZERO;
            deb_cnt_r   <= CNT_ZERO;
            rel_cnt_r   <= CNT_ZERO;
            lat_row_r   <= 2'd0;
            lat_col_r   <= 2'd0;
            key_code_r  <= KEY_NONE;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            row_n_r     <= row_n_s;
            step_cnt_r  <= step_cnt_s;
            deb_cnt_r   <= deb_cnt_s;
            rel_cnt_r   <= rel_cnt_s;
            lat_row_r   <= lat_row_s;
            lat_col_r   <= lat_col_s;
            key_code_r  <= key_code_s;
            key_valid_r <= key_valid_s;
            key_held_r  <= key_held_s;
        end
    end

    assign row_n     = row_n_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign key_held  = key_held_r;

endmodule
